// File: rtl/que_slot_pkg.sv
// Shared types and constants for the slot packet writer and its watchdog.
package que_slot_pkg;

  localparam int LEN_W = 11;

  localparam logic [LEN_W-1:0] DEF_MIN_LENGTH = 11'd60;
  localparam logic [LEN_W-1:0] DEF_MAX_LENGTH = 11'd1518;
  localparam logic [LEN_W-1:0] LEN_SAT        = '1;

  // Index of the final S_FLUSH cycle (counter runs 0,1,2).
  localparam logic [1:0] FLUSH_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_DROP,
    S_HOLD,
    S_FLUSH
  } state_t;

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] value);
    return (value == LEN_SAT) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/que_slot_packet_writer_timer.sv
// Down-counting cycle timer: load arms it, expired is high once it has run out.
module cycle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/que_slot_packet_writer.sv
// Writes received frame bytes into a single-frame slot FIFO and reports each
// frame as good (hold until consumed) or bad (flush), dropping frames that arrive while busy.
module que_slot_packet_writer
  import que_slot_pkg::*;
#(
  parameter logic [LEN_W-1:0] MIN_LENGTH = DEF_MIN_LENGTH,
  parameter logic [LEN_W-1:0] MAX_LENGTH = DEF_MAX_LENGTH,
  parameter logic [15:0]      RX_TIMEOUT = 16'h0100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  input  logic             rx_last,
  input  logic             rx_error,
  input  logic             fifo_full,
  input  logic             slot_ready,
  output logic [7:0]       fifo_write_data,
  output logic             fifo_write_enable,
  output logic             good_packet,
  output logic             bad_packet,
  output logic [LEN_W-1:0] frame_length,
  output logic [15:0]      drop_count
);

  state_t           state, state_next;
  logic [LEN_W-1:0] count, count_next, length_next;
  logic             err_flag, err_next, overflow, overflow_next;
  logic             seen_ready, seen_next;
  logic [1:0]       flush_cnt, flush_cnt_next;
  logic [7:0]       write_data_next;
  logic             write_enable_next, good_next, bad_next;
  logic [15:0]      drops_next;

  logic             expired, timed_out, frame_ok, err_now;
  logic [LEN_W-1:0] len_now;

  cycle_timer #(.WIDTH(16)) watchdog (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       ((state == S_IDLE) || rx_data_valid),
    .load_value (RX_TIMEOUT - 16'd1),
    .expired    (expired)
  );

  // Length and error status the frame would have if it closed on this byte.
  assign len_now   = (state == S_IDLE) ? 11'd1 : sat_inc(count);
  assign err_now   = ((state == S_IDLE) ? 1'b0 : err_flag) | rx_error;
  assign frame_ok  = !err_now && (len_now >= MIN_LENGTH) && (len_now <= MAX_LENGTH);
  assign timed_out = (state == S_WRITE) && !rx_data_valid && expired;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_WRITE: begin
        if (rx_data_valid) begin
          if (fifo_full)
            state_next = rx_last ? S_FLUSH : S_DROP;
          else if (rx_last)
            state_next = frame_ok ? S_HOLD : S_FLUSH;
          else
            state_next = S_WRITE;
        end else if (timed_out) begin
          state_next = S_FLUSH;
        end
      end
      S_DROP:
        if (rx_data_valid && rx_last) state_next = S_FLUSH;
      S_HOLD: begin
        if (rx_data_valid)
          state_next = rx_last ? S_FLUSH : S_DROP;
        else if (seen_ready && !slot_ready)
          state_next = S_IDLE;
      end
      S_FLUSH: begin
        if (rx_data_valid)
          state_next = rx_last ? S_FLUSH : S_DROP;
        else if (flush_cnt == FLUSH_LAST)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // A byte refused by a full FIFO turns the frame into an overflow drop, even on its first byte.
  always_comb begin
    write_enable_next = 1'b0;
    write_data_next   = fifo_write_data;
    good_next         = 1'b0;
    bad_next          = 1'b0;
    length_next       = frame_length;
    drops_next        = drop_count;
    count_next        = count;
    err_next          = err_flag;
    overflow_next     = overflow;
    seen_next         = 1'b0;
    flush_cnt_next    = '0;
    case (state)
      S_IDLE, S_WRITE: begin
        if (rx_data_valid) begin
          count_next    = len_now;
          overflow_next = fifo_full;
          if (fifo_full) begin
            err_next = 1'b1;
            if (rx_last) begin
              bad_next    = 1'b1;
              length_next = len_now;
            end
          end else begin
            write_enable_next = 1'b1;
            write_data_next   = rx_data;
            err_next          = err_now;
            if (rx_last) begin
              length_next = len_now;
              good_next   = frame_ok;
              bad_next    = !frame_ok;
            end
          end
        end else if (timed_out) begin
          bad_next    = 1'b1;
          length_next = count;
        end
      end
      S_DROP: begin
        if (rx_data_valid) begin
          count_next = sat_inc(count);
          if (rx_last && overflow) begin
            bad_next    = 1'b1;
            length_next = sat_inc(count);
          end
        end
      end
      S_HOLD: begin
        if (rx_data_valid) begin
          drops_next    = drop_count + 16'd1;
          overflow_next = 1'b0;
        end else if (!(seen_ready && !slot_ready)) begin
          seen_next = seen_ready | slot_ready;
        end
      end
      S_FLUSH: begin
        if (rx_data_valid) begin
          drops_next    = drop_count + 16'd1;
          overflow_next = 1'b0;
        end else begin
          flush_cnt_next = flush_cnt + 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_write_enable <= 1'b0;
      fifo_write_data   <= '0;
      good_packet       <= 1'b0;
      bad_packet        <= 1'b0;
      frame_length      <= '0;
      drop_count        <= '0;
      count             <= '0;
      err_flag          <= 1'b0;
      overflow          <= 1'b0;
      seen_ready        <= 1'b0;
      flush_cnt         <= '0;
    end else begin
      fifo_write_enable <= write_enable_next;
      fifo_write_data   <= write_data_next;
      good_packet       <= good_next;
      bad_packet        <= bad_next;
      frame_length      <= length_next;
      drop_count        <= drops_next;
      count             <= count_next;
      err_flag          <= err_next;
      overflow          <= overflow_next;
      seen_ready        <= seen_next;
      flush_cnt         <= flush_cnt_next;
    end
  end

endmodule

// File: tb/tb_que_slot_packet_writer.sv
// Self-checking bench for que_slot_packet_writer: directed frame scenarios with random
// payloads, checked against an expected-byte queue and frame-level outcome rules.
module tb_que_slot_packet_writer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_data_valid, rx_last, rx_error, fifo_full, slot_ready;
  logic [7:0]  fifo_write_data;
  logic        fifo_write_enable, good_packet, bad_packet;
  logic [10:0] frame_length;
  logic [15:0] drop_count;

  int total = 0;
  int fails = 0;
  int write_seen = 0, good_seen = 0, bad_seen = 0;
  int w0, g0, b0;
  logic [7:0] exp_q[$];

  que_slot_packet_writer dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .rx_data           (rx_data),
    .rx_data_valid     (rx_data_valid),
    .rx_last           (rx_last),
    .rx_error          (rx_error),
    .fifo_full         (fifo_full),
    .slot_ready        (slot_ready),
    .fifo_write_data   (fifo_write_data),
    .fifo_write_enable (fifo_write_enable),
    .good_packet       (good_packet),
    .bad_packet        (bad_packet),
    .frame_length      (frame_length),
    .drop_count        (drop_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Every FIFO write must carry the next byte the bench expects to be stored.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (fifo_write_enable) begin
        write_seen++;
        checkOutput("write_data", {24'd0, fifo_write_data},
                    (exp_q.size() > 0) ? {24'd0, exp_q.pop_front()} : 32'h100);
      end
      if (good_packet) good_seen++;
      if (bad_packet)  bad_seen++;
      if (good_packet || bad_packet)
        checkOutput("pulse_exclusive", {31'd0, good_packet & bad_packet}, 32'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx_data_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0; fifo_full = 1'b0;
    end
  endtask

  task automatic applyStimulus(input int len, input int err_idx, input int full_idx,
                               input bit do_last, input bit expect_written);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      rx_data       = 8'($urandom);
      rx_data_valid = 1'b1;
      rx_last       = do_last && (i == len - 1);
      rx_error      = (i == err_idx);
      fifo_full     = (i == full_idx);
      if (expect_written && (full_idx < 0 || i < full_idx))
        exp_q.push_back(rx_data);
    end
    idle(1);
  endtask

  task automatic mark();
    w0 = write_seen; g0 = good_seen; b0 = bad_seen;
  endtask

  task automatic checkFrame(input string tag, input int exp_writes, input bit exp_good,
                            input bit exp_bad, input int exp_len);
    #1;
    checkOutput({tag, "_writes"},   write_seen - w0, exp_writes);
    checkOutput({tag, "_good_cnt"}, good_seen - g0, {31'd0, exp_good});
    checkOutput({tag, "_bad_cnt"},  bad_seen - b0, {31'd0, exp_bad});
    checkOutput({tag, "_good_now"}, {31'd0, good_packet}, {31'd0, exp_good});
    checkOutput({tag, "_bad_now"},  {31'd0, bad_packet}, {31'd0, exp_bad});
    if (exp_len >= 0) checkOutput({tag, "_length"}, {21'd0, frame_length}, exp_len);
  endtask

  task automatic release_hold();
    slot_ready = 1'b1;
    idle(2);
    slot_ready = 1'b0;
    idle(2);
  endtask

  initial begin
    int len, err_idx;
    bit exp_good;
    reset_n = 1'b0; rx_data = '0; rx_data_valid = 1'b0; rx_last = 1'b0;
    rx_error = 1'b0; fifo_full = 1'b0; slot_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset_we",     {31'd0, fifo_write_enable}, 0);
    checkOutput("reset_data",   {24'd0, fifo_write_data}, 0);
    checkOutput("reset_good",   {31'd0, good_packet}, 0);
    checkOutput("reset_bad",    {31'd0, bad_packet}, 0);
    checkOutput("reset_length", {21'd0, frame_length}, 0);
    checkOutput("reset_drops",  {16'd0, drop_count}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(2);

    $display("[TB] 64-byte good frame");
    mark(); applyStimulus(64, -1, -1, 1, 1); checkFrame("good64", 64, 1, 0, 64);

    $display("[TB] frame arriving during hold is dropped whole");
    mark(); applyStimulus(20, -1, -1, 1, 0); checkFrame("hold_drop", 0, 0, 0, -1);
    checkOutput("hold_drop_count", {16'd0, drop_count}, 1);
    idle(5);

    len = $urandom_range(60, 300);
    mark(); applyStimulus(len, -1, -1, 1, 1); checkFrame("good_rand", len, 1, 0, len);
    slot_ready = 1'b1;
    idle(3);
    mark(); applyStimulus(5, -1, -1, 1, 0); checkFrame("ready_high_drop", 0, 0, 0, -1);
    checkOutput("ready_high_drop_count", {16'd0, drop_count}, 2);
    slot_ready = 1'b0;
    idle(5);

    mark(); applyStimulus(64, -1, -1, 1, 1); checkFrame("after_flush", 64, 1, 0, 64);
    release_hold();

    $display("[TB] 40-byte runt and three-cycle flush");
    mark(); applyStimulus(40, -1, -1, 1, 1); checkFrame("runt40", 40, 0, 1, 40);
    idle(1);
    mark(); applyStimulus(3, -1, -1, 1, 0); checkFrame("flush_drop", 0, 0, 0, -1);
    checkOutput("flush_drop_count", {16'd0, drop_count}, 3);
    idle(2);
    mark(); applyStimulus(64, -1, -1, 1, 1); checkFrame("post_flush", 64, 1, 0, 64);
    release_hold();

    $display("[TB] errored and overflowing frames");
    mark(); applyStimulus(100, 49, -1, 1, 1); checkFrame("rx_error", 100, 0, 1, 100);
    idle(4);
    mark(); applyStimulus(200, -1, 29, 1, 1); checkFrame("overflow", 29, 0, 1, -1);
    idle(4);

    $display("[TB] reset in the middle of a frame");
    mark(); applyStimulus(20, -1, -1, 0, 1);
    #2 reset_n = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("midreset_length", {21'd0, frame_length}, 0);
    checkOutput("midreset_drops",  {16'd0, drop_count}, 0);
    #1 reset_n = 1'b1;
    applyStimulus(64, -1, -1, 1, 1); checkFrame("post_reset", 84, 1, 0, 64);
    release_hold();

    $display("[TB] inter-byte stall boundaries");
    mark(); applyStimulus(10, -1, -1, 0, 1); idle(254);
    applyStimulus(54, -1, -1, 1, 1); checkFrame("stall255", 64, 1, 0, 64);
    release_hold();
    mark(); applyStimulus(10, -1, -1, 0, 1); idle(256);
    checkFrame("stall256", 10, 0, 1, -1);
    idle(2);
    mark(); applyStimulus(64, -1, -1, 1, 1); checkFrame("after_timeout", 64, 1, 0, 64);
    release_hold();

    $display("[TB] random frames with length boundaries");
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: len = 1;
        1: len = 59;
        2: len = 60;
        3: len = 1518;
        4: len = 1519;
        default: len = $urandom_range(2, 200);
      endcase
      err_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      exp_good = (err_idx < 0) && (len >= 60) && (len <= 1518);
      mark(); applyStimulus(len, err_idx, -1, 1, 1);
      checkFrame($sformatf("rand%0d", k), len, exp_good, !exp_good, len);
      if (exp_good) release_hold(); else idle(4);
    end

    $display("test done: total=%0d bad=%0d", total, fails);
    $finish;
  end

endmodule
